// File: rtl/cr16_datapath.sv
// CR16 register file plus ALU: sixteen general registers, combinational operand
// selection and ALU, per-register write-back and a per-bit enabled flag register.
module cr16_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [NREGS-1:0] enableRegs,
  input  logic [NREGS-1:0] resRegs,
  input  logic [7:0]       opCode,
  input  logic [4:0]       enableFlags,
  input  logic [3:0]       muxRsrc,
  input  logic [3:0]       muxRdest,
  input  logic             muxRI,
  input  logic [WIDTH-1:0] imm,
  input  logic [3:0]       dbgSel,
  output logic [WIDTH-1:0] aluResult,
  output logic [4:0]       flags,
  output logic [WIDTH-1:0] dbgData
);

  localparam logic [7:0] OP_AND  = 8'b0000_0001;
  localparam logic [7:0] OP_OR   = 8'b0000_0010;
  localparam logic [7:0] OP_XOR  = 8'b0000_0011;
  localparam logic [7:0] OP_ADD  = 8'b0000_0101;
  localparam logic [7:0] OP_ADDU = 8'b0000_0110;
  localparam logic [7:0] OP_ADDC = 8'b0000_0111;
  localparam logic [7:0] OP_SUB  = 8'b0000_1001;
  localparam logic [7:0] OP_SUBC = 8'b0000_1010;
  localparam logic [7:0] OP_CMP  = 8'b0000_1011;
  localparam logic [7:0] OP_MOV  = 8'b0000_1101;

  localparam int MSB = WIDTH - 1;

  // Flag vector positions
  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] reg_next [NREGS];
  logic [4:0]       flags_reg;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;
  logic [4:0]       flag_calc;
  logic             op_valid;
  logic             reg_wr;

  assign op_a = muxRI ? imm : regs[muxRdest];
  assign op_b = regs[muxRsrc];
  assign cin  = flags_reg[FC];

  always_comb begin
    result    = '0;
    sum       = '0;
    flag_calc = '0;
    op_valid  = 1'b1;
    case (opCode)
      OP_AND: result = op_a & op_b;
      OP_OR:  result = op_a | op_b;
      OP_XOR: result = op_a ^ op_b;
      OP_ADD, OP_ADDU, OP_ADDC: begin
        sum = {1'b0, op_a} + {1'b0, op_b}
            + {{WIDTH{1'b0}}, (opCode == OP_ADDC) ? cin : 1'b0};
        result        = sum[MSB:0];
        flag_calc[FC] = sum[WIDTH];
        flag_calc[FF] = (opCode != OP_ADDU) && (op_a[MSB] == op_b[MSB])
                        && (result[MSB] != op_a[MSB]);
      end
      OP_SUB, OP_SUBC, OP_CMP: begin
        // The extra top bit of the difference is the borrow out
        sum = {1'b0, op_a} - {1'b0, op_b}
            - {{WIDTH{1'b0}}, (opCode == OP_SUBC) ? cin : 1'b0};
        result        = sum[MSB:0];
        flag_calc[FC] = sum[WIDTH];
        flag_calc[FF] = (opCode != OP_CMP) && (op_a[MSB] != op_b[MSB])
                        && (result[MSB] != op_a[MSB]);
      end
      OP_MOV:  result = op_a;
      default: op_valid = 1'b0;
    endcase
    flag_calc[FZ] = (result == '0);
    flag_calc[FN] = result[MSB];
    if (opCode == OP_CMP) begin
      flag_calc[FZ] = (op_a == op_b);
      flag_calc[FN] = $signed(op_a) < $signed(op_b);
      flag_calc[FL] = op_a < op_b;
    end
  end

  assign reg_wr = op_valid && (opCode != OP_CMP);

  // Clear takes priority over a write to the same register
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wb
      assign reg_next[gi] = resRegs[gi] ? '0
                          : (enableRegs[gi] && reg_wr) ? result
                          : regs[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      flags_reg <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= reg_next[i];
      end
      for (int j = 0; j < 5; j++) begin
        if (op_valid && enableFlags[j]) begin
          flags_reg[j] <= flag_calc[j];
        end
      end
    end
  end

  assign aluResult = result;
  assign flags     = flags_reg;
  assign dbgData   = regs[dbgSel];

endmodule
